// File: rtl/ether2usb_pkt_fifo_ptr_ckpt.sv
// Wrapping circular-buffer pointer with a checkpoint register for packet
// rollback. DEPTH need not be a power of two, so the wrap is explicit.
module fifo_ptr_ckpt #(
  parameter int DEPTH = 1500,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             ckpt_set,
  input  logic             restore,
  output logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] ckpt,
  output logic [PTR_W-1:0] ptr_next
);

  assign ptr_next = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr  <= '0;
      ckpt <= '0;
    end else begin
      // restore wins over advance; caller already masks en on restore
      if (restore)  ptr <= ckpt;
      else if (en)  ptr <= ptr_next;
      // checkpoint captures the pre-update pointer
      if (ckpt_set) ckpt <= ptr;
    end
  end

endmodule

// File: rtl/ether2usb_pkt_fifo.sv
// Byte FIFO between Ethernet and USB with per-side packet checkpoints:
// write_error discards a partial frame, read_error replays a frame.
module ether2usb_pkt_fifo #(
  parameter int DEPTH  = 1500,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              write_enable,
  input  logic              write_start,
  input  logic              write_error,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_enable,
  input  logic              read_start,
  input  logic              read_error,
  output logic [DATA_W-1:0] read_data,
  output logic              fifo_empty,
  output logic              fifo_full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr, wr_ckpt, wptr_next;
  logic [PTR_W-1:0]  rptr, rd_ckpt, rptr_next;
  logic              we, re;

  // full is judged against the read checkpoint so bytes already popped in
  // the current packet stay intact for a possible replay
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr_next == rd_ckpt);

  assign we = write_enable && !fifo_full  && !write_error && !rst && !clear;
  assign re = read_enable  && !fifo_empty && !read_error  && !rst && !clear;

  fifo_ptr_ckpt #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .en       (we),
    .ckpt_set (write_start),
    .restore  (write_error),
    .ptr      (wptr),
    .ckpt     (wr_ckpt),
    .ptr_next (wptr_next)
  );

  fifo_ptr_ckpt #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .en       (re),
    .ckpt_set (read_start),
    .restore  (read_error),
    .ptr      (rptr),
    .ckpt     (rd_ckpt),
    .ptr_next (rptr_next)
  );

  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= write_data;
  end

  // clear flushes pointers but deliberately leaves the last popped byte visible
  always_ff @(posedge clk) begin
    if (rst)     read_data <= '0;
    else if (re) read_data <= mem[rptr];
  end

endmodule

// File: tb/tb_ether2usb_pkt_fifo.sv
// Directed bench for ether2usb_pkt_fifo: fill/drain, write rollback,
// read replay, clear and simultaneous traffic.
module tb_ether2usb_pkt_fifo;

  logic       tb_clk = 1'b0;
  logic       rst, clear;
  logic       write_enable, write_start, write_error;
  logic [7:0] write_data;
  logic       read_enable, read_start, read_error;
  logic [7:0] read_data;
  logic       fifo_empty, fifo_full;

  int tests = 0;
  int fails = 0;

  always #5 tb_clk = ~tb_clk;

  ether2usb_pkt_fifo #(.DEPTH(1500), .DATA_W(8)) dut (
    .clk          (tb_clk),
    .rst          (rst),
    .clear        (clear),
    .write_enable (write_enable),
    .write_start  (write_start),
    .write_error  (write_error),
    .write_data   (write_data),
    .read_enable  (read_enable),
    .read_start   (read_start),
    .read_error   (read_error),
    .read_data    (read_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full)
  );

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; clear = 0;
    write_enable = 0; write_start = 0; write_error = 0; write_data = '0;
    read_enable = 0; read_start = 0; read_error = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", fifo_empty); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", fifo_full); end
    tests++; if (read_data !== 8'h00) begin fails++; $display("FAIL reset_rdata got %h exp 00", read_data); end
  endtask

  task automatic test_single_byte();
    do_reset();
    write_enable = 1; write_start = 1; write_data = 8'hFF;
    tick();
    idle();
    tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL single_empty_after_wr got %b exp 0", fifo_empty); end
    read_enable = 1; read_start = 1;
    tick();
    idle();
    tests++; if (read_data !== 8'hFF) begin fails++; $display("FAIL single_rdata got %h exp ff", read_data); end
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL single_empty_after_rd got %b exp 1", fifo_empty); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL single_full got %b exp 0", fifo_full); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 1499; i++) begin
      write_enable = 1; write_start = (i == 0); write_data = 8'(i);
      tick();
      tests++; if (fifo_full !== (i == 1498)) begin fails++; $display("FAIL fill_full[%0d] got %b exp %b", i, fifo_full, (i == 1498)); end
      tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL fill_empty[%0d] got %b exp 0", i, fifo_empty); end
    end
    write_enable = 1; write_start = 0; write_data = 8'hAA;
    tick();
    idle();
    tests++; if (fifo_full !== 1'b1) begin fails++; $display("FAIL fill_drop_full got %b exp 1", fifo_full); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 1499; i++) begin
      read_enable = 1; read_start = (i == 0);
      tick();
      tests++; if (read_data !== 8'(i)) begin fails++; $display("FAIL drain_rdata[%0d] got %h exp %h", i, read_data, 8'(i)); end
    end
    idle();
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL drain_empty got %b exp 1", fifo_empty); end
  endtask

  task automatic read_frame_750(input string tag);
    for (int i = 0; i < 749; i++) begin
      read_enable = 1; read_start = (i == 0);
      tick();
      tests++; if (read_data !== 8'(750 + i)) begin fails++; $display("FAIL %s_rdata[%0d] got %h exp %h", tag, i, read_data, 8'(750 + i)); end
    end
    idle();
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL %s_empty got %b exp 1", tag, fifo_empty); end
  endtask

  task automatic test_write_rollback();
    do_reset();
    for (int i = 0; i < 750; i++) begin
      write_enable = 1; write_start = (i == 0); write_data = 8'(i);
      tick();
    end
    idle();
    write_error = 1; write_enable = 1; write_data = 8'h55;
    tick();
    idle();
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL rollback_empty got %b exp 1", fifo_empty); end
    for (int i = 750; i < 1499; i++) begin
      write_enable = 1; write_start = (i == 750); write_data = 8'(i);
      tick();
    end
    idle();
    read_frame_750("rollback");
  endtask

  task automatic test_read_replay();
    read_error = 1; read_enable = 1;
    tick();
    idle();
    tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL replay_empty got %b exp 0", fifo_empty); end
    tests++; if (read_data !== 8'hDA) begin fails++; $display("FAIL replay_hold got %h exp da", read_data); end
    read_frame_750("replay");
  endtask

  task automatic test_read_empty();
    read_enable = 1;
    tick();
    tick();
    idle();
    tests++; if (read_data !== 8'hDA) begin fails++; $display("FAIL rd_empty_hold got %h exp da", read_data); end
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL rd_empty_flag got %b exp 1", fifo_empty); end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      write_enable = 1; write_start = (i == 0); write_data = 8'(8'h10 + i);
      tick();
    end
    idle();
    read_enable = 1; read_start = 1;
    tick();
    idle();
    tests++; if (read_data !== 8'h10) begin fails++; $display("FAIL clear_pre_rdata got %h exp 10", read_data); end
    clear = 1; write_enable = 1; read_enable = 1; write_data = 8'h77;
    tick();
    idle();
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL clear_empty got %b exp 1", fifo_empty); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL clear_full got %b exp 0", fifo_full); end
    tests++; if (read_data !== 8'h10) begin fails++; $display("FAIL clear_rdata_hold got %h exp 10", read_data); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      write_enable = 1; write_start = (i == 0); write_data = 8'(8'h40 + i);
      tick();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      write_enable = 1; write_data = 8'(8'h4A + i);
      read_enable = 1; read_start = (i == 0);
      tick();
      tests++; if (read_data !== 8'(8'h40 + i)) begin fails++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, read_data, 8'(8'h40 + i)); end
      tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL b2b_empty[%0d] got %b exp 0", i, fifo_empty); end
    end
    idle();
    // occupancy must still be 10: exactly ten more pops reach empty
    for (int i = 0; i < 10; i++) begin
      tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL b2b_occ[%0d] got empty %b exp 0", i, fifo_empty); end
      read_enable = 1;
      tick();
      tests++; if (read_data !== 8'(8'h45 + i)) begin fails++; $display("FAIL b2b_tail[%0d] got %h exp %h", i, read_data, 8'(8'h45 + i)); end
    end
    idle();
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL b2b_final_empty got %b exp 1", fifo_empty); end
  endtask

  initial begin
    idle();
    test_reset();
    test_single_byte();
    test_fill();
    test_drain();
    test_write_rollback();
    test_read_replay();
    test_read_empty();
    test_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
